// File: rtl/bw_mac_pkg.sv
// -----------------------------------------------------------------------------
// bw_mac_pkg
//   Shared definitions for the Baugh-Wooley MAC accumulator slice:
//   FSM state encoding, default width constants and the product
//   sign-extension helper.
//   Optional feature macro: BW_MAC_SAT_EN (saturating accumulation).
// -----------------------------------------------------------------------------
package bw_mac_pkg;

   localparam int PROD_W_DEF    = 8;
   localparam int ACC_W_DEF     = 10;
   localparam int MAX_TERMS_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Sign-extends the low from_w bits of value to 32 bits. from_w is a
   // constant at every call site, so this reduces to plain wiring.
   function automatic logic [31:0] sign_extend(input logic [31:0] value,
                                               input int          from_w);
      logic signed [31:0] shifted;
      shifted = value << (32 - from_w);
      return shifted >>> (32 - from_w);
   endfunction

endpackage

// File: rtl/bw_sat_add.sv
// -----------------------------------------------------------------------------
// bw_sat_add
//   ACC_W-bit signed adder with an overflow flag.
//   BW_MAC_SAT_EN defined   : result clamps to the signed ACC_W range and
//                             ovf flags every clamp.
//   BW_MAC_SAT_EN undefined : wrap-around (modulo 2^ACC_W) addition, ovf = 0.
// Ports
//   a, b  in   ACC_W  signed operands
//   sum   out  ACC_W  signed result
//   ovf   out  1      a clamp occurred on this addition
// -----------------------------------------------------------------------------
module bw_sat_add
   import bw_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

`ifdef BW_MAC_SAT_EN
   logic [ACC_W:0] wide;

   // One guard bit is enough: the two top bits of the sign-extended sum
   // disagree exactly when the true result leaves the ACC_W range.
   assign wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sum = wide[ACC_W-1:0];
      ovf = 1'b0;
      if (wide[ACC_W] != wide[ACC_W-1]) begin
         ovf = 1'b1;
         sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign sum = a + b;
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/bw_mac_acc.sv
// -----------------------------------------------------------------------------
// bw_mac_acc
//   Accumulates signed multiplier products into a dot product of up to
//   MAX_TERMS terms and presents the result under valid/ready.
//   Optional feature macro: BW_MAC_SAT_EN (saturating sum + sticky ovf_o);
//   without it the sum wraps and ovf_o is constant 0.
// Ports
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   clr_i        in   1       synchronous abort: back to IDLE, beat discarded
//   prod_i       in   PROD_W  signed product
//   in_valid_i   in   1       prod_i valid
//   in_last_i    in   1       beat closes the dot product
//   in_ready_o   out  1       a beat can be accepted (not holding a result)
//   acc_o        out  ACC_W   signed dot-product result
//   cnt_o        out  CNT_W   number of terms in acc_o
//   ovf_o        out  1       a clamp occurred while forming acc_o
//   out_valid_o  out  1       result valid
//   out_ready_i  in   1       consumer takes the result
// -----------------------------------------------------------------------------
module bw_mac_acc
   import bw_mac_pkg::*;
#(
   parameter int   PROD_W    = PROD_W_DEF,
   parameter int   ACC_W     = ACC_W_DEF,
   parameter int   MAX_TERMS = MAX_TERMS_DEF,
   localparam int  CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic [PROD_W-1:0] prod_i,
   input  logic              in_valid_i,
   input  logic              in_last_i,
   output logic              in_ready_o,
   output logic [ACC_W-1:0]  acc_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              ovf_o,
   output logic              out_valid_o,
   input  logic              out_ready_i
);

   state_t             state;
   state_t             state_next;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;

   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   sum;
   logic               sum_ovf;
   logic [CNT_W-1:0]   cnt_inc;
   logic               beat;
   logic               close;
   logic               hand_off;

   assign in_ready_o = (state != HOLD);
   assign beat       = in_valid_i & in_ready_o;
   assign cnt_inc    = cnt + CNT_W'(1);
   // A full accumulator closes the sum even without in_last_i.
   assign close      = beat & (in_last_i | (cnt_inc == CNT_W'(MAX_TERMS)));
   assign hand_off   = (state == HOLD) & out_ready_i;

   assign prod_ext   = ACC_W'(sign_extend(32'(prod_i), PROD_W));

   // acc is zero whenever the FSM is in IDLE, so the first beat of a sum
   // simply loads the product through the same adder.
   bw_sat_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a   (acc),
      .b   (prod_ext),
      .sum (sum),
      .ovf (sum_ovf)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, ACCUM: if (beat)        state_next = close ? HOLD : ACCUM;
         HOLD:        if (out_ready_i) state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         acc_o       <= '0;
         cnt_o       <= '0;
         ovf_o       <= 1'b0;
         out_valid_o <= 1'b0;
      end else if (clr_i) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         out_valid_o <= 1'b0;
      end else begin
         state <= state_next;
         if (beat) begin
            acc <= sum;
            cnt <= cnt_inc;
            ovf <= ovf | sum_ovf;
            if (close) begin
               acc_o       <= sum;
               cnt_o       <= cnt_inc;
               ovf_o       <= ovf | sum_ovf;
               out_valid_o <= 1'b1;
            end
         end else if (hand_off) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule
